// File: rtl/q15_add_arbiter.sv
// q15_add_arbiter
//   Round-robin arbiter that shares one combinational Q15 64-bit saturating
//   adder among NREQ requesters. The winner's sum lands in a single
//   registered result slot, which is tagged with the requester index.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   req_valid    [NREQ]      per-requester operation valid
//   req_a/req_b  [NREQ*64]   operands; slice i = bits [64*i+63:64*i]
//   req_ready    [NREQ]      one-hot grant (combinational)
//   res_valid    result slot holds a valid result
//   res_ready    downstream accepts the result
//   res_data     [64]        Q15 sum
//   res_id       [IDW]       index of the requester that produced res_data
//   res_nan      res_data is the NaN code
//   res_sat      res_data is +inf or -inf
//
// Optional feature (macro Q15_ARB_STATS_EN)
//   Adds stat_nan_cnt / stat_sat_cnt. Each is a 32-bit saturating count of
//   result-port handshakes that carried res_nan / res_sat.
//
// Note on NaN aliasing: a plain in-range sum can equal 64'h8000000000000000
// (for example c000.. + c000..). It is reported with res_nan=1 because the
// flag describes the output code, not how the code was produced. The same
// applies to res_sat for in-range sums equal to either inf code.
module q15_add_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*64-1:0] req_a,
  input  logic [NREQ*64-1:0] req_b,
  output logic [NREQ-1:0]    req_ready,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [63:0]        res_data,
  output logic [IDW-1:0]     res_id,
  output logic               res_nan,
  output logic               res_sat
`ifdef Q15_ARB_STATS_EN
  ,
  output logic [31:0]        stat_nan_cnt,
  output logic [31:0]        stat_sat_cnt
`endif
);

  localparam logic [63:0] NAN_CODE = 64'h8000_0000_0000_0000;
  localparam logic [63:0] POS_INF  = 64'h7fff_ffff_ffff_ffff;
  localparam logic [63:0] NEG_INF  = 64'h8000_0000_0000_0001;

  // Q15 saturating add with NaN/inf special codes.
  // The direction of saturation follows bit 63 of the wrapped sum. This also
  // applies when an inf operand is involved.
  function automatic logic [63:0] q15_sat_add(input logic [63:0] a,
                                              input logic [63:0] b);
    logic [63:0] wsum;
    logic        a_nan;
    logic        b_nan;
    logic        a_inf;
    logic        b_inf;
    logic        ovf;
    logic [63:0] res;
    wsum  = a + b;
    a_nan = (a == NAN_CODE);
    b_nan = (b == NAN_CODE);
    a_inf = (a == POS_INF) || (a == NEG_INF);
    b_inf = (b == POS_INF) || (b == NEG_INF);
    ovf   = (a[63] == b[63]) && (wsum[63] != a[63]);
    if (a_nan || b_nan || (a_inf && b_inf)) begin
      res = NAN_CODE;
    end else if (a_inf || b_inf || ovf) begin
      res = wsum[63] ? POS_INF : NEG_INF;
    end else begin
      res = wsum;
    end
    return res;
  endfunction

  function automatic logic is_nan_code(input logic [63:0] d);
    return (d == NAN_CODE);
  endfunction

  function automatic logic is_sat_code(input logic [63:0] d);
    return (d == POS_INF) || (d == NEG_INF);
  endfunction

  logic [IDW-1:0] rr_ptr_r;
  logic           slot_free_s;
  logic           gvalid_s;
  logic [IDW-1:0] gidx_s;
  logic [NREQ-1:0] grant_s;
  logic [63:0]    a_sel_s;
  logic [63:0]    b_sel_s;
  logic [63:0]    sum_s;
  logic [IDW-1:0] rr_next_s;

  // Grants are suppressed during reset so that no operand is consumed on an
  // edge that also clears the slot.
  assign slot_free_s = !reset && (!res_valid || res_ready);
  assign req_ready   = grant_s;

  // Round-robin search: the first valid requester at or after rr_ptr wins.
  always_comb begin
    logic [IDW:0]   pos_v;
    logic [IDW-1:0] idx_v;
    logic           found_v;
    pos_v   = '0;
    idx_v   = '0;
    found_v = 1'b0;
    gidx_s  = '0;
    grant_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos_v = {1'b0, rr_ptr_r} + (IDW+1)'(k);
      if (pos_v >= (IDW+1)'(NREQ)) begin
        pos_v = pos_v - (IDW+1)'(NREQ);
      end else begin
        pos_v = pos_v;
      end
      idx_v = pos_v[IDW-1:0];
      if (!found_v && slot_free_s && req_valid[idx_v]) begin
        found_v = 1'b1;
        gidx_s  = idx_v;
      end else begin
        found_v = found_v;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      grant_s[i] = found_v && (gidx_s == IDW'(i));
    end
    gvalid_s = found_v;
  end

  // Operand mux driven by the one-hot grant, followed by the shared adder.
  always_comb begin
    a_sel_s = '0;
    b_sel_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_sel_s = a_sel_s | ({64{grant_s[i]}} & req_a[64*i +: 64]);
      b_sel_s = b_sel_s | ({64{grant_s[i]}} & req_b[64*i +: 64]);
    end
    sum_s = q15_sat_add(a_sel_s, b_sel_s);
  end

  // The pointer moves to the requester after the winner, modulo NREQ.
  always_comb begin
    if (gidx_s == IDW'(NREQ - 1)) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = gidx_s + IDW'(1);
    end
  end

  // Result slot and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r  <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      res_nan   <= 1'b0;
      res_sat   <= 1'b0;
    end else if (gvalid_s) begin
      rr_ptr_r  <= rr_next_s;
      res_valid <= 1'b1;
      res_data  <= sum_s;
      res_id    <= gidx_s;
      res_nan   <= is_nan_code(sum_s);
      res_sat   <= is_sat_code(sum_s);
    end else if (slot_free_s) begin
      res_valid <= 1'b0;
    end else begin
      res_valid <= res_valid;
    end
  end

`ifdef Q15_ARB_STATS_EN
  // Saturating counters of NaN / saturated results at each output handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_nan_cnt <= 32'h0000_0000;
      stat_sat_cnt <= 32'h0000_0000;
    end else begin
      if (res_valid && res_ready && res_nan && (stat_nan_cnt != 32'hffff_ffff)) begin
        stat_nan_cnt <= stat_nan_cnt + 32'h0000_0001;
      end else begin
        stat_nan_cnt <= stat_nan_cnt;
      end
      if (res_valid && res_ready && res_sat && (stat_sat_cnt != 32'hffff_ffff)) begin
        stat_sat_cnt <= stat_sat_cnt + 32'h0000_0001;
      end else begin
        stat_sat_cnt <= stat_sat_cnt;
      end
    end
  end
`endif

endmodule

// File: doc/q15_add_arbiter.md
Name: q15_add_arbiter

Overview:
- Shares one combinational Q15 64-bit saturating adder among NREQ requesters.
- Round-robin arbitration, valid/ready handshakes on every requester port and on the single result port.
- One registered result stage; each result is tagged with the requester index.
- Sits between the shader/ray datapath units and the shared Q15 add resource.

Parameters:
- NREQ, 4, number of requester ports (2..16)
- IDW, 2, width of requester index; must satisfy 2**IDW >= NREQ

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester operation valid
- req_a  in  NREQ*64  operand A per requester; slice i = bits [64*i+63:64*i]; signed Q15
- req_b  in  NREQ*64  operand B per requester; same slicing
- req_ready  out  NREQ  one-hot grant; requester i's operands consumed at edge where req_valid[i] & req_ready[i]
- res_valid  out  1  result register holds a valid result
- res_ready  in  1  downstream accepts result
- res_data  out  64  Q15 sum
- res_id  out  IDW  index of the requester that produced res_data
- res_nan  out  1  res_data == 64'h8000000000000000
- res_sat  out  1  res_data == 64'h7fffffffffffffff or 64'h8000000000000001

Behaviour:
- Adder semantics: NaN code 64'h8000000000000000. +inf code 64'h7fffffffffffffff. -inf code 64'h8000000000000001.
- NaN result if either operand is NaN, or both operands are inf. Result is then 64'h8000000000000000.
- Otherwise an inf operand, or two same-sign operands whose wrapped sum changes sign, gives a saturation result. Output is 64'h7fffffffffffffff if the wrapped sum bit 63 = 1, else 64'h8000000000000001.
- All other cases: plain two's-complement sum.
- State: rr_ptr (IDW bits), result register {res_valid, res_data, res_id, res_nan, res_sat}.
- Reset values: rr_ptr = 0, res_valid = 0, res_data = 0, res_id = 0, res_nan = 0, res_sat = 0, req_ready = 0.
- Slot free = !res_valid | res_ready (drain and refill in the same cycle is allowed).
- Grant rule: when slot free, grant the first i with req_valid[i] = 1, scanning rr_ptr, rr_ptr+1, ... modulo NREQ. req_ready is combinational, one-hot or all-zero, and never asserted when slot not free.
- On grant g: next edge loads the adder result of req_a[g] and req_b[g], sets res_id = g and res_valid = 1, and sets rr_ptr = (g+1) mod NREQ.
- No grant while slot free: res_valid clears if it was drained; rr_ptr unchanged.
- Slot not free (res_valid & !res_ready): all result outputs held stable; rr_ptr unchanged.
- Latency: accept at edge T, res_valid high after edge T. Full throughput: one result per cycle while res_ready = 1.
- Requesters must hold req_a/req_b stable while req_valid & !req_ready. Dropping req_valid before grant is permitted; no state is kept for it.
- Starvation bound: a continuously valid requester is granted within NREQ slot-free cycles.
- reset asserted mid-operation: the in-flight result is discarded with no handshake, all state returns to reset values, and req_ready = 0 during the reset cycle.
- Indices >= NREQ are never granted (IDW slack ignored).

Optional Feature:
- Macro Q15_ARB_STATS_EN.
- Defined: adds output ports stat_nan_cnt (32 bits) and stat_sat_cnt (32 bits). Each counter increments by 1 at every result-port handshake (res_valid & res_ready) with res_nan or res_sat set respectively. Counters saturate at 32'hffffffff and clear on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Single op on req 2: a=64'h8000, b=64'h8000, res_ready=1 -> req_ready=4'b0100 that cycle; next cycle res_valid=1, res_data=64'h10000, res_id=2, res_nan=0, res_sat=0.
- Overflow: a=b=64'h4000000000000000 -> res_data=64'h7fffffffffffffff, res_sat=1. Also a=b=64'hc000000000000000 -> res_data=64'h8000000000000000 arithmetically exact, so res_nan=1, res_sat=0 (document NaN aliasing).
- NaN/inf: a=64'h8000000000000000, b=5 -> res_nan=1. a=64'h7fffffffffffffff, b=64'h8000000000000001 -> res_data=64'h8000000000000000.
- Round robin: all four req_valid held high, res_ready=1 for 8 cycles -> res_id sequence 0,1,2,3,0,1,2,3 on consecutive cycles.
- Backpressure: result pending, res_ready=0 for 3 cycles -> res_data/res_id stable, req_ready=0. On res_ready=1, the same-cycle grant goes to the next requester after the held one.
- Reset mid-stream: reset pulsed for 1 cycle while res_valid=1 -> res_valid=0, next grant goes to req 0. With Q15_ARB_STATS_EN: 3 saturating results -> stat_sat_cnt=3, reset -> 0.
